// File: rtl/color_change_tracker_if.sv
// color_change_tracker_if: colour strobe inputs and accepted-colour outputs of the tracker
interface color_change_tracker_if #(
  parameter int NUM_COLORS = 3,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = (NUM_COLORS < 2) ? 1 : $clog2(NUM_COLORS);
  logic [NUM_COLORS-1:0] color_in;
  logic                  clear_count;
  logic                  color_valid;
  logic [IDX_W-1:0]      color_idx;
  logic                  change_pulse;
  logic [CNT_W-1:0]      change_count;
  logic                  multi_hot_err;
  modport master (
    output color_in, clear_count,
    input  color_valid, color_idx, change_pulse, change_count, multi_hot_err
  );
  modport slave (
    input  color_in, clear_count,
    output color_valid, color_idx, change_pulse, change_count, multi_hot_err
  );
endinterface

// File: rtl/color_change_tracker.sv
// color_change_tracker: debounced N-colour decoder with change pulse and saturating change counter
module color_change_tracker #(
  parameter int NUM_COLORS     = 3,
  parameter int STABLE_CYCLES  = 1,
  parameter int CNT_W          = 8,
  parameter int MULTI_HOT_MODE = 0,
  parameter int PULSE_ON_WHITE = 0
) (
  input logic                     clk,
  input logic                     reset,
  color_change_tracker_if.slave   bus
);
  localparam int IDX_W = (NUM_COLORS < 2) ? 1 : $clog2(NUM_COLORS);
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic             raw_valid;
  logic [IDX_W-1:0] raw_idx;
  logic             multi;
  logic             same_cand;
  logic             accept;
  logic             cand_valid_q, cand_valid_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             acc_valid_q, acc_valid_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Downward scan leaves the lowest set index as the winner.
  always_comb begin
    raw_valid = 1'b0;
    raw_idx   = '0;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (bus.color_in[i]) begin
        raw_valid = 1'b1;
        raw_idx   = IDX_W'(i);
      end
    end
    multi = |(bus.color_in & (bus.color_in - NUM_COLORS'(1)));
    if (MULTI_HOT_MODE != 0 && multi) begin
      raw_valid = 1'b0;
      raw_idx   = '0;
    end
  end

  always_comb begin
    same_cand    = {raw_valid, raw_idx} == {cand_valid_q, cand_idx_q};
    cand_valid_d = raw_valid;
    cand_idx_d   = raw_idx;
    run_len_d    = !same_cand ? RUN_W'(1) :
                   (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_W'(1);
    accept       = (run_len_d == RUN_MAX) && ({raw_valid, raw_idx} != {acc_valid_q, acc_idx_q});
    acc_valid_d  = accept ? raw_valid : acc_valid_q;
    acc_idx_d    = accept ? raw_idx : acc_idx_q;
    pulse_d      = accept && (raw_valid || PULSE_ON_WHITE != 0);
    count_d      = bus.clear_count ? '0 :
                   (pulse_d && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    err_d        = multi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_valid_q <= 1'b0;
      cand_idx_q   <= '0;
      run_len_q    <= '0;
      acc_valid_q  <= 1'b0;
      acc_idx_q    <= '0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      cand_valid_q <= cand_valid_d;
      cand_idx_q   <= cand_idx_d;
      run_len_q    <= run_len_d;
      acc_valid_q  <= acc_valid_d;
      acc_idx_q    <= acc_idx_d;
      pulse_q      <= pulse_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign bus.color_valid   = acc_valid_q;
  assign bus.color_idx     = acc_idx_q;
  assign bus.change_pulse  = pulse_q;
  assign bus.change_count  = count_q;
  assign bus.multi_hot_err = err_q;
endmodule

// File: doc/color_change_tracker.md
Name: color_change_tracker

Overview:
- Parametrised N-colour input tracker for the colour-sensor FSM path.
- Decodes an N-bit colour strobe vector into an accepted colour (or "white" = no colour).
- Qualifies each candidate with a programmable debounce, flags changes with a registered one-cycle pulse, and counts changes in a saturating counter.
- Sits between the sensor input synchroniser and the colour-event logic. Supports direct colour-to-colour transitions and multi-hot handling.

Parameters:
- NUM_COLORS, 3: number of colour input lines (>=2). localparam IDX_W = max(1, $clog2(NUM_COLORS)).
- STABLE_CYCLES, 1: consecutive sampling edges a candidate must persist before acceptance (>=1).
- CNT_W, 8: change counter width.
- MULTI_HOT_MODE, 0: 0 = multi-hot resolves to lowest set index; 1 = multi-hot treated as white.
- PULSE_ON_WHITE, 0: 1 = colour->white transitions also pulse and count.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset.
- color_in, input, NUM_COLORS: bit i = colour i present.
- clear_count, input, 1: synchronous clear of change_count.
- color_valid, output, 1: accepted state is a colour (0 = white).
- color_idx, output, IDX_W: accepted colour index; 0 when color_valid=0.
- change_pulse, output, 1: one-cycle pulse on accepted change.
- change_count, output, CNT_W: saturating count of change_pulse events.
- multi_hot_err, output, 1: registered; previous sample had >1 bit set.

Behaviour:
- Reset (sync, sampled at posedge) clears all of the following: color_valid, color_idx, change_pulse, change_count, multi_hot_err, cand_q (= white) and run_len. Reset overrides every other input. An in-progress qualification is discarded.
- raw (combinational) is derived from color_in:
  - all-zero -> white.
  - one-hot -> that index.
  - multi-hot -> lowest set index (MODE 0) or white (MODE 1).
- Debounce, on each non-reset edge:
  - if raw == cand_q: run_len <= min(run_len+1, STABLE_CYCLES);
  - else: cand_q <= raw, run_len <= 1.
  - run_len width = $clog2(STABLE_CYCLES+1). It saturates and does not wrap.
- Acceptance: let run_next be the run_len value being written this edge. If run_next == STABLE_CYCLES and raw != accepted state, the accepted state (color_valid/color_idx) <= raw at this edge.
  - Latency is STABLE_CYCLES edges from the first edge raw is stable.
  - With STABLE_CYCLES=1, outputs follow raw with 1-cycle latency.
- Transitions are white->X, X->Y (direct; no intermediate white) and X->white.
- change_pulse is registered. It is 1 for exactly the cycle following an acceptance edge whose transition is white->X or X->Y, or X->white if PULSE_ON_WHITE=1. It is 0 otherwise, including re-acceptance of the same state (which cannot occur).
- change_count:
  - clear_count -> 0 (priority over increment on the same edge).
  - Otherwise it increments on each acceptance edge that asserts change_pulse, saturating at 2^CNT_W-1.
- multi_hot_err <= (popcount(color_in) > 1) every non-reset edge, in both modes. It does not affect the debounce.
- A glitch shorter than STABLE_CYCLES produces no change of accepted state, no pulse and no count.
- A candidate that changes mid-qualification restarts at run_len=1 with the new candidate.

Test Plan:
- Defaults; reset 2 cycles; color_in=001 for 3 cycles -> after 1st edge color_valid=1, color_idx=0; change_pulse=1 for one cycle; change_count=1.
- Defaults; 001 -> 010 (direct) -> 000 -> color_idx=1 with pulse, count=2; then color_valid=0, color_idx=0, no pulse, count stays 2. Repeat with PULSE_ON_WHITE=1 -> count=3.
- STABLE_CYCLES=3; 100 for 2 cycles, then 000 -> no acceptance, no pulse. Then 100 held -> color_idx=2 accepted on 3rd edge, single pulse.
- MULTI_HOT_MODE=0, color_in=011 -> color_idx=0, multi_hot_err=1 one cycle later. MULTI_HOT_MODE=1, same input -> color_valid=0, err=1, no pulse.
- CNT_W=2; 5 alternating changes -> change_count saturates at 3. Then clear_count asserted on an acceptance edge -> change_count=0, change_pulse still 1.
- STABLE_CYCLES=4; reset asserted after 2 stable edges of 010 with input held -> outputs 0. Acceptance occurs exactly 4 edges after reset deasserts.
